nn_frame_sched: RTL

//  Ping-pong frame buffer and launch scheduler in front of the QuantCNN core.
//  The filtered/binarized pixel stream fills one 32x32x8 bank while the CNN reads the other.

---
 rtl/nn_sched_pkg.sv | 12 +
 rtl/nn_pingpong_ram.sv | 31 +++
 rtl/nn_frame_sched.sv | 139 +++++++++++++
 3 files changed

// File: rtl/nn_sched_pkg.sv
// Shared types and defaults for the QuantCNN frame scheduler.
package nn_sched_pkg;
  localparam int NN_ADDR_W = 10;
  localparam int NN_DATA_W = 8;
  localparam int NN_RES_W  = 32;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_START, S_RUN} sched_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/nn_pingpong_ram.sv
// Two-bank pixel store: the writer fills bank[wr_sel], the CNN reads bank[~wr_sel].
module nn_pingpong_ram
  import nn_sched_pkg::*;
#(
  parameter int ADDR_W = NN_ADDR_W,
  parameter int DATA_W = NN_DATA_W
) (
  input  logic              gclk,
  input  logic              wr_sel,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] bank0 [2**ADDR_W];
  logic [DATA_W-1:0] bank1 [2**ADDR_W];
  logic [DATA_W-1:0] rd0_q, rd1_q;
  logic              rd_sel_q;

  // Both banks read every cycle so each maps onto a plain BRAM; the mux picks afterwards.
  always_ff @(posedge gclk) begin
    if (wr_en && !wr_sel) bank0[wr_addr] <= wr_data;
    if (wr_en &&  wr_sel) bank1[wr_addr] <= wr_data;
    rd0_q    <= bank0[rd_addr];
    rd1_q    <= bank1[rd_addr];
    rd_sel_q <= ~wr_sel;
  end

  assign rd_data = rd_sel_q ? rd1_q : rd0_q;
endmodule

// File: rtl/nn_frame_sched.sv
// Ping-pong frame buffer and CNN launch scheduler.
// Optional watchdog on START/RUN enabled by defining NN_SCHED_TIMEOUT_EN.
module nn_frame_sched
  import nn_sched_pkg::*;
#(
  parameter int ADDR_W  = NN_ADDR_W,
  parameter int DATA_W  = NN_DATA_W,
  parameter int RES_W   = NN_RES_W,
  parameter int TMO_CYC = 2000000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cfg_cont,
  input  logic              cfg_oneshot,
  input  logic              pix_en,
  input  logic [ADDR_W-1:0] pix_addr,
  input  logic [DATA_W-1:0] pix_data,
  input  logic              frame_end,
  input  logic              nn_idle,
  output logic              nn_start,
  input  logic [ADDR_W-1:0] nn_raddr,
  output logic [DATA_W-1:0] nn_rdata,
  input  logic              nn_vld,
  input  logic [RES_W-1:0]  nn_res,
  output logic [RES_W-1:0]  res_data,
  output logic              res_vld,
  output logic              busy,
  output logic [7:0]        drop_cnt,
  output logic              tmo_err
);
  sched_state_t     state_q;
  logic             wr_sel_q, pend_q, pend_d;
  logic             nn_start_q, res_vld_q;
  logic [RES_W-1:0] res_q;
  logic [7:0]       drop_q, drop_d;
  logic             go, swap, drop, tmo_hit;

  nn_pingpong_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .gclk   (CLK),
    .wr_sel (wr_sel_q),
    .wr_en  (pix_en),
    .wr_addr(pix_addr),
    .wr_data(pix_data),
    .rd_addr(nn_raddr),
    .rd_data(nn_rdata)
  );

`ifdef NN_SCHED_TIMEOUT_EN
  logic [31:0] tmo_cnt_q;
  logic        tmo_err_q, in_core, leave;

  assign in_core = (state_q == S_START) || (state_q == S_RUN);
  assign leave   = ((state_q == S_START) && !nn_idle) || ((state_q == S_RUN) && nn_vld);
  assign tmo_hit = in_core && (tmo_cnt_q == 32'(TMO_CYC - 1));

  // Counts cycles spent in the current START/RUN visit; any state change restarts it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= (in_core && !leave && !tmo_hit) ? tmo_cnt_q + 32'd1 : '0;
      if (tmo_hit) tmo_err_q <= 1'b1;
    end
  end
  assign tmo_err = tmo_err_q;
`else
  assign tmo_hit = 1'b0;
  assign tmo_err = 1'b0;
`endif

  always_comb begin
    go     = pend_q | cfg_cont;
    swap   = !tmo_hit && frame_end &&
             ((state_q == S_WAIT) || ((state_q == S_RUN) && nn_vld && go));
    // Any completed frame that does not reach the CNN is a drop.
    drop   = frame_end && !swap && (state_q != S_WAIT);
    pend_d = (swap || tmo_hit) ? 1'b0 : (pend_q | cfg_oneshot | cfg_cont);
    drop_d = drop ? sat_inc8(drop_q) : drop_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_sel_q <= 1'b0;
      pend_q   <= 1'b0;
      drop_q   <= '0;
    end else begin
      wr_sel_q <= wr_sel_q ^ swap;
      pend_q   <= pend_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      nn_start_q <= 1'b0;
      res_q      <= '0;
      res_vld_q  <= 1'b0;
    end else begin
      res_vld_q <= 1'b0;
      if (tmo_hit) begin
        state_q    <= S_IDLE;
        nn_start_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE:  if (pend_q) state_q <= S_WAIT;
          S_WAIT:  if (swap) begin
                     state_q    <= S_START;
                     nn_start_q <= 1'b1;
                   end
          S_START: if (!nn_idle) begin
                     state_q    <= S_RUN;
                     nn_start_q <= 1'b0;
                   end
          S_RUN:   if (nn_vld) begin
                     res_q     <= nn_res;
                     res_vld_q <= 1'b1;
                     if (swap) begin
                       state_q    <= S_START;
                       nn_start_q <= 1'b1;
                     end else if (go && !frame_end) begin
                       state_q <= S_WAIT;
                     end else begin
                       state_q <= S_IDLE;
                     end
                   end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign nn_start = nn_start_q;
  assign res_data = res_q;
  assign res_vld  = res_vld_q;
  assign busy     = (state_q != S_IDLE);
  assign drop_cnt = drop_q;
endmodule
